// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS control unit: opcodes, controller
// states and the datapath mux encodings driven by the controller.
package mips_pkg;

    localparam int OPC_W = 6;

    typedef enum logic [OPC_W-1:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_MEMADR,
        ST_MEMRD,
        ST_MEMWB,
        ST_MEMWR,
        ST_EXEC,
        ST_ALUWB,
        ST_ADDIEX,
        ST_ADDIWB,
        ST_BRANCH,
        ST_JUMP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        ASB_REG      = 2'b00,
        ASB_FOUR     = 2'b01,
        ASB_SEXT     = 2'b10,
        ASB_SEXT_SH2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'b00,
        PCS_ALUOUT = 2'b01,
        PCS_JUMP   = 2'b10
    } pc_src_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. The controller side is the master: it
// drives the strobes and mux selects and observes opcode, zero and mem_ready.
interface mips_multicycle_ctrl_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;

    logic                iord;
    logic                mem_rd;
    logic                mem_wr;
    logic                ir_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                reg_write;
    logic                alu_src_a;
    logic [1:0]          alu_src_b;
    logic [1:0]          alu_op;
    logic [1:0]          pc_src;
    logic                pc_en;
    logic                illegal_op;
    logic                instr_done;
    logic [CNT_W-1:0]    retired_cnt;

    modport master (
        input  opcode, zero, mem_ready,
        output iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               illegal_op, instr_done, retired_cnt
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  iord, mem_rd, mem_wr, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
               illegal_op, instr_done, retired_cnt
    );

endinterface

// File: rtl/mips_multicycle_ctrl_retire_counter.sv
// Free-running retired-instruction counter; wraps silently at 2^CNT_W.
module mips_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per retire pulse, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | one dead cycle after reset, all outputs low
// FETCH   | read instruction at PC, PC+4 -> PC and IR when memory ready
// DECODE  | compute branch target into ALUOut, dispatch on opcode
// MEMADR  | base + offset for LW/SW
// MEMRD   | LW data read, waits for memory
// MEMWB   | LW write-back from MDR into rt
// MEMWR   | SW data write, strobe held until memory ready
// EXEC    | R-type ALU operation
// ALUWB   | R-type write-back into rd
// ADDIEX  | A + sign-extended immediate
// ADDIWB  | ADDI write-back into rt
// BRANCH  | compare A/B, load PC from ALUOut on taken BEQ/BNE
// JUMP    | load PC with jump target
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32,
    parameter bit WAIT_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    mips_multicycle_ctrl_if.master bus
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    logic        rdy;
    logic        retire;

    logic is_rtype;
    logic is_addi;
    logic is_lw;
    logic is_sw;
    logic is_beq;
    logic is_bne;
    logic is_j;

    // With wait states disabled the memory is assumed to finish every access in one cycle.
    assign rdy = WAIT_EN ? bus.mem_ready : 1'b1;

    // Opcode classification; only consulted by the states that sample opcode.
    always_comb begin
        is_rtype = (bus.opcode == OPCODE_W'(OP_RTYPE));
        is_addi  = (bus.opcode == OPCODE_W'(OP_ADDI));
        is_lw    = (bus.opcode == OPCODE_W'(OP_LW));
        is_sw    = (bus.opcode == OPCODE_W'(OP_SW));
        is_beq   = (bus.opcode == OPCODE_W'(OP_BEQ));
        is_bne   = (bus.opcode == OPCODE_W'(OP_BNE));
        is_j     = (bus.opcode == OPCODE_W'(OP_J));
    end

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore output decode; pc_en/ir_write also look at rdy and zero.
    always_comb begin
        state_nxt      = state;
        retire         = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ASB_REG;
        bus.alu_op     = ALU_ADD;
        bus.pc_src     = PCS_ALU;
        bus.pc_en      = 1'b0;
        bus.illegal_op = 1'b0;

        unique case (state)
            ST_IDLE: begin
                state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = ASB_FOUR;
                bus.ir_write  = rdy;
                bus.pc_en     = rdy;
                if (rdy) begin
                    state_nxt = ST_DECODE;
                end
            end

            ST_DECODE: begin
                bus.alu_src_b = ASB_SEXT_SH2;
                if (is_lw || is_sw) begin
                    state_nxt = ST_MEMADR;
                end else if (is_rtype) begin
                    state_nxt = ST_EXEC;
                end else if (is_addi) begin
                    state_nxt = ST_ADDIEX;
                end else if (is_beq || is_bne) begin
                    state_nxt = ST_BRANCH;
                end else if (is_j) begin
                    state_nxt = ST_JUMP;
                end else begin
                    // Unknown opcode: flag it and drop the instruction without retiring it.
                    bus.illegal_op = 1'b1;
                    state_nxt      = ST_FETCH;
                end
            end

            ST_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_SEXT;
                state_nxt     = is_lw ? ST_MEMRD : ST_MEMWR;
            end

            ST_MEMRD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
                if (rdy) begin
                    state_nxt = ST_MEMWB;
                end
            end

            ST_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                retire         = 1'b1;
                state_nxt      = ST_FETCH;
            end

            ST_MEMWR: begin
                // Strobe stays up for the whole wait so the memory sees one continuous write.
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
                if (rdy) begin
                    retire    = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end

            ST_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_REG;
                bus.alu_op    = ALU_FUNCT;
                state_nxt     = ST_ALUWB;
            end

            ST_ALUWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
                retire        = 1'b1;
                state_nxt     = ST_FETCH;
            end

            ST_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_SEXT;
                state_nxt     = ST_ADDIWB;
            end

            ST_ADDIWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_nxt     = ST_FETCH;
            end

            ST_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_REG;
                bus.alu_op    = ALU_SUB;
                bus.pc_src    = PCS_ALUOUT;
                bus.pc_en     = is_bne ? ~bus.zero : bus.zero;
                retire        = 1'b1;
                state_nxt     = ST_FETCH;
            end

            ST_JUMP: begin
                bus.pc_src = PCS_JUMP;
                bus.pc_en  = 1'b1;
                retire     = 1'b1;
                state_nxt  = ST_FETCH;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.instr_done = retire;

    mips_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (retire),
        .count (bus.retired_cnt)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for the multicycle MIPS controller. Each instruction is expanded
// into its cycle-by-cycle phase list (including memory wait cycles) and the
// expected control word for every cycle is derived from the phase, the
// memory-ready value and the zero flag.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_nw = 1'b1;

    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.OPCODE_W(6), .CNT_W(32)) bus_a ();
    mips_multicycle_ctrl_if #(.OPCODE_W(6), .CNT_W(4))  bus_b ();
    mips_multicycle_ctrl_if #(.OPCODE_W(6), .CNT_W(4))  bus_nw ();

    mips_multicycle_ctrl #(.OPCODE_W(6), .CNT_W(32), .WAIT_EN(1'b1)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    mips_multicycle_ctrl #(.OPCODE_W(6), .CNT_W(4), .WAIT_EN(1'b1)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );
    mips_multicycle_ctrl #(.OPCODE_W(6), .CNT_W(4), .WAIT_EN(1'b0)) dut_nw (
        .clk (clk), .rst (rst_nw), .bus (bus_nw)
    );

    assign bus_b.opcode    = bus_a.opcode;
    assign bus_b.zero      = bus_a.zero;
    assign bus_b.mem_ready = bus_a.mem_ready;

    typedef struct packed {
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
        logic       instr_done;
    } cw_t;

    typedef enum {
        P_FETCH, P_DEC, P_ADDR, P_RD, P_RDWB, P_WR,
        P_EX, P_EXWB, P_AIEX, P_AIWB, P_BR, P_JMP
    } phase_t;

    typedef struct {
        phase_t ph;
        bit     ready;
    } cyc_t;

    localparam int C_R = 0, C_ADDI = 1, C_LW = 2, C_SW = 3,
                   C_BEQ = 4, C_BNE = 5, C_J = 6, C_ILL = 7;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic cw_t actual_a();
        cw_t w;
        w.iord       = bus_a.iord;
        w.mem_rd     = bus_a.mem_rd;
        w.mem_wr     = bus_a.mem_wr;
        w.ir_write   = bus_a.ir_write;
        w.reg_dst    = bus_a.reg_dst;
        w.mem_to_reg = bus_a.mem_to_reg;
        w.reg_write  = bus_a.reg_write;
        w.alu_src_a  = bus_a.alu_src_a;
        w.alu_src_b  = bus_a.alu_src_b;
        w.alu_op     = bus_a.alu_op;
        w.pc_src     = bus_a.pc_src;
        w.pc_en      = bus_a.pc_en;
        w.illegal_op = bus_a.illegal_op;
        w.instr_done = bus_a.instr_done;
        return w;
    endfunction

    function automatic logic [5:0] class_opcode(input int cls);
        case (cls)
            C_R:     return 6'h00;
            C_ADDI:  return 6'h08;
            C_LW:    return 6'h23;
            C_SW:    return 6'h2B;
            C_BEQ:   return 6'h04;
            C_BNE:   return 6'h05;
            default: return 6'h02;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2B};
    endfunction

    // Control word the datapath should see in one cycle of the given phase.
    function automatic cw_t expect_cw(input phase_t ph, input bit rdy, input bit z,
                                      input bit bne, input bit ill);
        cw_t w = '0;
        case (ph)
            P_FETCH: begin
                w.mem_rd = 1; w.alu_src_b = 2'b01;
                w.ir_write = rdy; w.pc_en = rdy;
            end
            P_DEC:  begin w.alu_src_b = 2'b11; w.illegal_op = ill; end
            P_ADDR: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
            P_RD:   begin w.mem_rd = 1; w.iord = 1; end
            P_RDWB: begin w.reg_write = 1; w.mem_to_reg = 1; w.instr_done = 1; end
            P_WR:   begin w.mem_wr = 1; w.iord = 1; w.instr_done = rdy; end
            P_EX:   begin w.alu_src_a = 1; w.alu_op = 2'b10; end
            P_EXWB: begin w.reg_write = 1; w.reg_dst = 1; w.instr_done = 1; end
            P_AIEX: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
            P_AIWB: begin w.reg_write = 1; w.instr_done = 1; end
            P_BR: begin
                w.alu_src_a = 1; w.alu_op = 2'b01; w.pc_src = 2'b01;
                w.pc_en = bne ? ~z : z; w.instr_done = 1;
            end
            P_JMP:  begin w.pc_src = 2'b10; w.pc_en = 1; w.instr_done = 1; end
            default: w = '0;
        endcase
        return w;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_cw"}, 64'(actual_a()), 64'(cw_t'('0)));
        check({tag, "_cnt"}, 64'(bus_a.retired_cnt), 64'(0));
        check({tag, "_cnt4"}, 64'(bus_b.retired_cnt), 64'(0));
    endtask

    // Entered just after a rising edge; the following cycle must be IDLE.
    task automatic idle_cycle();
        @(negedge clk);
        check_idle("idle");
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle reset: outputs must collapse immediately, then IDLE follows release.
    task automatic do_abort();
        #1 rst = 1'b1;
        #1 check_idle("rst_async");
        exp_cnt = '0;
        @(posedge clk);
        #1 check_idle("rst_hold");
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic run_instr(input int cls, input int wf, input int wm, input int zmode,
                             input logic [5:0] ill_opc, input int abort_at);
        cyc_t       plan[$];
        logic [5:0] opc;
        cw_t        expw;
        opc = (cls == C_ILL) ? ill_opc : class_opcode(cls);
        for (int k = 0; k < wf; k++) plan.push_back('{P_FETCH, 1'b0});
        plan.push_back('{P_FETCH, 1'b1});
        plan.push_back('{P_DEC, 1'($urandom_range(0, 1))});
        case (cls)
            C_R:    begin plan.push_back('{P_EX, 1'b1}); plan.push_back('{P_EXWB, 1'b1}); end
            C_ADDI: begin plan.push_back('{P_AIEX, 1'b1}); plan.push_back('{P_AIWB, 1'b0}); end
            C_LW: begin
                plan.push_back('{P_ADDR, 1'b0});
                for (int k = 0; k < wm; k++) plan.push_back('{P_RD, 1'b0});
                plan.push_back('{P_RD, 1'b1});
                plan.push_back('{P_RDWB, 1'($urandom_range(0, 1))});
            end
            C_SW: begin
                plan.push_back('{P_ADDR, 1'b1});
                for (int k = 0; k < wm; k++) plan.push_back('{P_WR, 1'b0});
                plan.push_back('{P_WR, 1'b1});
            end
            C_BEQ, C_BNE: plan.push_back('{P_BR, 1'($urandom_range(0, 1))});
            C_J:    plan.push_back('{P_JMP, 1'($urandom_range(0, 1))});
            default: ;
        endcase
        for (int i = 0; i < plan.size(); i++) begin
            bus_a.mem_ready = plan[i].ready;
            bus_a.zero      = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (plan[i].ph inside {P_DEC, P_ADDR, P_BR}) bus_a.opcode = opc;
            else bus_a.opcode = 6'($urandom);
            @(negedge clk);
            expw = expect_cw(plan[i].ph, plan[i].ready, bus_a.zero,
                             cls == C_BNE, cls == C_ILL);
            check($sformatf("cw_c%0d_i%0d", cls, i), 64'(actual_a()), 64'(expw));
            check("cnt32", 64'(bus_a.retired_cnt), 64'(exp_cnt));
            check("cnt4", 64'(bus_b.retired_cnt), 64'(exp_cnt[3:0]));
            if (i == abort_at) begin
                do_abort();
                return;
            end
            @(posedge clk);
            #1;
            if (expw.instr_done) exp_cnt = exp_cnt + 32'd1;
        end
    endtask

    // Wait states disabled: mem_ready held low must not stall a stream of jumps.
    initial begin
        bus_nw.opcode    = 6'h02;
        bus_nw.zero      = 1'b0;
        bus_nw.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_nw = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("nw_done", 64'(bus_nw.instr_done), 64'(c > 0 && c % 3 == 0));
            check("nw_irw", 64'(bus_nw.ir_write), 64'(c % 3 == 1));
        end
        check("nw_cnt", 64'(bus_nw.retired_cnt), 64'(9));
    end

    initial begin
        int         cls;
        logic [5:0] ill;
        bus_a.opcode    = 6'h00;
        bus_a.zero      = 1'b0;
        bus_a.mem_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        rst = 1'b0;
        idle_cycle();

        run_instr(C_R,    0, 0, -1, 6'h00, -1);
        run_instr(C_LW,   0, 2, -1, 6'h00, -1);
        run_instr(C_BEQ,  0, 0,  1, 6'h00, -1);
        run_instr(C_BEQ,  0, 0,  0, 6'h00, -1);
        run_instr(C_BNE,  0, 0,  0, 6'h00, -1);
        run_instr(C_BNE,  0, 0,  1, 6'h00, -1);
        run_instr(C_ILL,  0, 0, -1, 6'h3F, -1);
        run_instr(C_ADDI, 1, 0, -1, 6'h00, -1);
        run_instr(C_SW,   1, 1, -1, 6'h00, -1);
        run_instr(C_SW,   0, 3, -1, 6'h00, 4);
        run_instr(C_R,    2, 0, -1, 6'h00, 1);
        for (int n = 0; n < 17; n++) run_instr(C_J, 0, 0, -1, 6'h00, -1);
        check("wrap_cnt4", 64'(bus_b.retired_cnt), 64'(1));

        for (int n = 0; n < 60; n++) begin
            cls = int'($urandom_range(0, 7));
            ill = 6'h3F;
            if (cls == C_ILL) begin
                do ill = 6'($urandom); while (is_legal(ill));
            end
            run_instr(cls, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      -1, ill, -1);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
